dm_ctrl: RTL and testbench

Load/store initiator driving the word-addressed 4 KB data memory (10-bit word address, 32-bit write data, write strobe, combinational read data, write on rising clock edge). It accepts one byte, halfword or word access at a time from the CPU datapath and sequences the memory port. Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended. The block sits between the execute stage and the data memory and reports completion with a one-cycle `done` pulse.

---
 rtl/dm_ctrl_pkg.sv | 13 +
 rtl/dm_lane_merge.sv | 24 ++
 rtl/dm_ctrl.sv | 96 +++++++++
 tb/tb_dm_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: access-size encoding, controller states and alignment check shared by dm_ctrl.
package dm_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_e;

  // The reserved size code 2'b11 is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/dm_lane_merge.sv
// dm_lane_merge: little-endian store lane merge and load extract/extend for one 32-bit memory word.
module dm_lane_merge
  import dm_ctrl_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] merged_o,
  output logic [31:0] ext_o
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] lane;
  always_comb begin
    sh       = {off_i, 3'b000};
    mask     = size_i == SZ_BYTE ? 32'h0000_00FF << sh : size_i == SZ_HALF ? 32'h0000_FFFF << sh : '1;
    merged_o = (old_i & ~mask) | ((wdata_i << sh) & mask);
    lane     = old_i >> sh;
    ext_o    = size_i == SZ_BYTE ? {{24{~uns_i & lane[7]}}, lane[7:0]} :
               size_i == SZ_HALF ? {{16{~uns_i & lane[15]}}, lane[15:0]} : old_i;
  end
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: load/store sequencer for the word-addressed data memory; sub-word stores use read-modify-write.
// Define DM_CTRL_RANGE_CHECK_EN to reject addresses beyond the memory instead of wrapping them.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_wr,
  input  logic [31:0]       dm_dout
);
  state_e            state_q, state_d;
  logic              we_q, uns_q, busy_q, done_q, err_q, dm_wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, dm_din_q, merged, ext;
  logic              range_bad, bad;
`ifdef DM_CTRL_RANGE_CHECK_EN
  assign range_bad = |addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign range_bad      = 1'b0;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];
`endif
  assign bad = misaligned(size, addr[1:0]) || range_bad;

  dm_lane_merge u_merge (
    .old_i   (dm_dout),
    .wdata_i (wdata_q),
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .uns_i   (uns_q),
    .merged_o(merged),
    .ext_o   (ext)
  );

  always_comb begin
    state_d = state_q == S_IDLE ? (!req ? S_IDLE : bad ? S_ERR : (we && size == SZ_WORD) ? S_WR : S_RD) :
              state_q == S_RD   ? (we_q ? S_WR : S_DONE) :
              state_q == S_WR   ? S_DONE : S_IDLE;
  end

  // Handshake outputs trail the DONE/ERR state by one cycle, so done lands in the cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dm_din_q <= '0;
      dm_wr_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        uns_q   <= uns;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
      end
      if (state_q == S_RD && !we_q) rdata_q <= ext;
      dm_wr_q  <= state_d == S_WR;
      dm_din_q <= state_d != S_WR ? '0 : state_q == S_IDLE ? wdata : merged;
      busy_q   <= state_d != S_IDLE || state_q == S_DONE || state_q == S_ERR;
      done_q   <= state_q == S_DONE || state_q == S_ERR;
      err_q    <= state_q == S_ERR;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign dm_addr = addr_q[ADDR_W+1:2];
  assign dm_din  = dm_din_q;
  assign dm_wr   = dm_wr_q;
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed and randomized accesses to dm_ctrl against a byte-level memory/load reference model.
module tb_dm_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0, mem_clr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, dm_wr;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rdata = '0;
  int          checks = 0, errors = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  dm_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_wr(dm_wr), .dm_dout(dm_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    else if (dm_wr) begin
      mem[dm_addr] <= dm_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access: starts at a negedge, returns at the negedge where done is seen (req already low).
  task automatic access(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] d);
    int nb, o, wi, lat, nwr, exp_lat;
    logic bad, busy_ok;
    logic [31:0] exp_word, exp_rd, ones;
    nb = 1 << sz; o = int'(a[1:0]); wi = int'(a[11:2]); ones = '1;
    bad = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && o != 0);
`ifdef DM_CTRL_RANGE_CHECK_EN
    bad = bad || (a >> 12) != 0;
`endif
    exp_word = ref_mem[wi];
    exp_rd   = ref_rdata;
    if (!bad && w) for (int i = 0; i < nb; i++) exp_word[8*(o+i) +: 8] = d[8*i +: 8];
    if (!bad && !w) begin
      exp_rd = '0;
      for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = exp_word[8*(o+i) +: 8];
      if (nb < 4 && !u && exp_rd[8*nb-1]) exp_rd = exp_rd | (ones << (8*nb));
    end
    exp_lat = bad ? 2 : (w && sz != 2'd2) ? 4 : 3;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    lat = 0; nwr = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (dm_wr) begin
        nwr++;
        check("wr_addr", 32'(dm_addr), 32'(wi));
        check("wr_data", dm_din, exp_word);
      end
      if (done) begin
        lat = n;
        break;
      end
      req = 1'($urandom); we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    end
    req = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("err", 32'(err), 32'(bad));
    check("rdata", rdata, exp_rd);
    check("busy", 32'(busy_ok), 32'd1);
    check("writes", 32'(nwr), (!bad && w) ? 32'd1 : 32'd0);
    check("mem", mem[wi], exp_word);
    ref_mem[wi] = exp_word;
    ref_rdata   = exp_rd;
  endtask

  initial begin
    int n0;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dm_wr", 32'(dm_wr), 0);
    check("rst_rdata", rdata, 0);
    check("rst_dm_addr", 32'(dm_addr), 0);
    check("rst_dm_din", dm_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF);
    access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    check("plan_word_load", rdata, 32'hDEAD_BEEF);
    access(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344);
    access(1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00AB);
    check("plan_byte_store", mem[0], 32'h11AB_3344);
    access(1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF_7F01);
    access(1'b0, 2'd0, 1'b0, 32'h2, 32'h0);
    check("plan_lb", rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    check("plan_lhu", rdata, 32'h0000_80FF);
    access(1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    check("plan_lh", rdata, 32'h0000_7F01);
    access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    check("plan_misalign_rdata", rdata, 32'h0000_7F01);
    access(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D);

    // Reset while the read half of a byte store is in flight.
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h10; wdata = 32'h77;
    @(posedge clk);
    req = 1'b0;
    @(negedge clk);
    n0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dm_wr", 32'(dm_wr), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_writes", 32'(wr_cnt), 32'(n0));
    check("rst_mid_mem", mem[4], ref_mem[4]);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    ref_rdata = '0;
    check("rst_mid_rdata", rdata, ref_rdata);

    for (int t = 0; t < 400; t++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
